// File: rtl/data_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl_if
// Request/response bus between an RV32I core (master) and data_mem_ctrl
// (slave).
//   req_valid  master->slave  request present
//   req_ready  slave->master  slave can accept a request this cycle
//   req_we     master->slave  1 = store, 0 = load
//   req_addr   master->slave  byte address (ADDR_W bits)
//   req_wdata  master->slave  store data, low bytes used for SB/SH
//   req_fn3    master->slave  RV32I load/store funct3
//   rsp_valid  slave->master  one-cycle response pulse
//   rsp_rdata  slave->master  extended load data, 0 for stores/errors
//   rsp_err    slave->master  access was suppressed
// -----------------------------------------------------------------------------
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [2:0]        req_fn3;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_fn3,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_fn3,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Byte-addressable little-endian data memory for the RV32I core with a
// valid/ready request handshake, registered loads and a programmable number
// of wait states. Handles LB/LH/LW/LBU/LHU/SB/SH/SW and flags illegal funct3,
// out-of-range and (optionally) misaligned accesses.
//
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset (memory contents are kept)
//   bus  - data_mem_ctrl_if.slave: req_valid/req_ready/req_we/req_addr/
//          req_wdata/req_fn3 in, rsp_valid/rsp_rdata/rsp_err out
//
// Parameters: DEPTH_BYTES (power of two, >= 4), ADDR_W, WAIT_CYCLES (0..15).
//
// Build option: define DMEM_MISALIGN_TRAP_EN to turn misaligned half/word
// accesses into errors; otherwise they are carried out byte by byte.
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int DEPTH_BYTES = 4096,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_ctrl_if.slave bus
);

  localparam int LOG2_DEPTH = $clog2(DEPTH_BYTES);
  localparam int ROW_W      = (LOG2_DEPTH > 2) ? LOG2_DEPTH - 2 : 1;
  localparam int BANK_DEPTH = DEPTH_BYTES / 4;
  localparam int EXT_W      = ADDR_W + 1;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP_MISALIGN = 1'b1;
`else
  localparam bit TRAP_MISALIGN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              capture;

  // Captured request
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        fn3_q;

  // Registered response
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  // ---------------------------------------------------------------------------
  // Decode of the captured request (stable from capture until the next one)
  // ---------------------------------------------------------------------------
  logic [2:0]       size_m1;     // access size in bytes minus one: 0, 1 or 3
  logic             illegal_fn3;
  logic             range_err;
  logic             misalign;
  logic             access_err;
  logic [EXT_W-1:0] last_byte;   // one extra bit so addr near 2^ADDR_W cannot wrap

  always_comb begin
    case (fn3_q[1:0])
      2'b01:   size_m1 = 3'd1;
      2'b10:   size_m1 = 3'd3;
      default: size_m1 = 3'd0;
    endcase
    // Loads reject 011/110/111, stores reject 011 and 1xx.
    illegal_fn3 = (fn3_q[1:0] == 2'b11) || (fn3_q[2] && (we_q || fn3_q[1]));
    last_byte   = {1'b0, addr_q} + EXT_W'(size_m1);
    range_err   = (last_byte >= EXT_W'(DEPTH_BYTES));
    misalign    = ((fn3_q[1:0] == 2'b01) && addr_q[0]) ||
                  ((fn3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    access_err  = illegal_fn3 || range_err || (TRAP_MISALIGN && misalign);
  end

  // ---------------------------------------------------------------------------
  // Storage: four byte lanes, lane b holds every address with addr[1:0]==b.
  // Any four consecutive bytes hit each lane exactly once, so an aligned or
  // misaligned access needs only one read/write port per lane.
  // ---------------------------------------------------------------------------
  logic [31:0] lane_rd;
  logic        wr_fire;

  assign wr_fire = (state_q == S_ACCESS) && we_q && !access_err && !rst;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [1:0]       offs;      // byte index within the access that maps here
      logic [ROW_W-1:0] row;
      logic [7:0]       lane_mem [BANK_DEPTH];
      logic [7:0]       rd_q;

      assign offs = 2'(gi) - addr_q[1:0];
      assign row  = ROW_W'((addr_q[LOG2_DEPTH-1:0] + LOG2_DEPTH'(offs)) >> 2);

      always_ff @(posedge clk) begin
        if (wr_fire && ({1'b0, offs} <= size_m1)) begin
          lane_mem[row] <= wdata_q[{offs, 3'b000} +: 8];
        end
        if (state_q == S_ACCESS) begin
          rd_q <= lane_mem[row];
        end
      end

      assign lane_rd[8*gi +: 8] = rd_q;
    end
  endgenerate

  // Re-order lanes into access byte order, then extend per funct3.
  logic [31:0] raw;
  logic [31:0] load_val;

  always_comb begin
    raw = '0;
    for (int k = 0; k < 4; k++) begin
      raw[8*k +: 8] = lane_rd[{2'(addr_q[1:0] + 2'(k)), 3'b000} +: 8];
    end
    case (fn3_q)
      3'b000:  load_val = {{24{raw[7]}}, raw[7:0]};
      3'b001:  load_val = {{16{raw[15]}}, raw[15:0]};
      3'b010:  load_val = raw;
      3'b100:  load_val = {24'd0, raw[7:0]};
      3'b101:  load_val = {16'd0, raw[15:0]};
      default: load_val = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM. ACCESS performs the write and the registered lane read;
  // RESP formats the read data and registers the response, which therefore
  // appears as a one-cycle rsp_valid pulse two edges after ACCESS begins.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    capture     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          capture    = 1'b1;
          wait_cnt_d = 4'(WAIT_CYCLES);
          state_d    = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == 4'd1) begin
          state_d = S_ACCESS;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = (we_q || access_err) ? 32'd0 : load_val;
        rsp_err_d   = access_err;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      fn3_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      if (capture) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        fn3_q   <= bus.req_fn3;
      end
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
// Three data_mem_ctrl instances (WAIT_CYCLES 0, 3, 2) share one clock. The
// driver issues one request at a time, runs a byte-array reference model and
// pushes the expected response (instance, cycle, rdata, err) into a
// scoreboard queue; a negedge monitor pops and compares on every rsp_valid.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;
  localparam int DEPTH = 256;
  localparam int NDUT  = 3;
  localparam int WAITS [NDUT] = '{0, 3, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-instance stimulus and observation
  logic [NDUT-1:0] rst_t;
  logic [NDUT-1:0] req_valid_t;
  logic [NDUT-1:0] req_we_t;
  logic [31:0]     req_addr_t  [NDUT];
  logic [31:0]     req_wdata_t [NDUT];
  logic [2:0]      req_fn3_t   [NDUT];
  logic [NDUT-1:0] rdy_t;
  logic [NDUT-1:0] rsp_valid_t;
  logic [31:0]     rsp_rdata_t [NDUT];
  logic [NDUT-1:0] rsp_err_t;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    data_mem_ctrl_if #(.ADDR_W(32)) bus ();
    data_mem_ctrl #(
      .DEPTH_BYTES(DEPTH),
      .ADDR_W     (32),
      .WAIT_CYCLES(WAITS[gi])
    ) dut (
      .clk(clk),
      .rst(rst_t[gi]),
      .bus(bus)
    );
    assign bus.req_valid   = req_valid_t[gi];
    assign bus.req_we      = req_we_t[gi];
    assign bus.req_addr    = req_addr_t[gi];
    assign bus.req_wdata   = req_wdata_t[gi];
    assign bus.req_fn3     = req_fn3_t[gi];
    assign rdy_t[gi]       = bus.req_ready;
    assign rsp_valid_t[gi] = bus.rsp_valid;
    assign rsp_rdata_t[gi] = bus.rsp_rdata;
    assign rsp_err_t[gi]   = bus.rsp_err;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard and counters
  // ---------------------------------------------------------------------------
  typedef struct {
    int          inst;
    int unsigned cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h required %08h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at cyc %0d", name, cyc);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: plain byte arrays, one per instance
  // ---------------------------------------------------------------------------
  logic [7:0] ref_mem [NDUT][DEPTH];

  function automatic void model(input int d, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [2:0] fn3,
                                output logic [31:0] rdata, output logic err);
    int          size;
    longint      last;
    logic [31:0] v;
    rdata = '0;
    err   = 1'b0;
    case (fn3)
      3'd0:    size = 1;
      3'd1:    size = 2;
      3'd2:    size = 4;
      3'd4:    size = we ? 0 : 1;
      3'd5:    size = we ? 0 : 2;
      default: size = 0;
    endcase
    if (size == 0) begin
      err = 1'b1;
      return;
    end
    last = longint'(addr) + longint'(size) - 1;
    if (last >= DEPTH) begin
      err = 1'b1;
      return;
    end
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((int'(addr) % size) != 0) begin
      err = 1'b1;
      return;
    end
`endif
    if (we) begin
      for (int i = 0; i < size; i++) ref_mem[d][int'(addr) + i] = wdata[8*i +: 8];
      return;
    end
    v = '0;
    for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[d][int'(addr) + i];
    if (fn3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (fn3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    rdata = v;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (rsp_valid_t[d] === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: inst %0d got rsp_valid=1 required none (cyc %0d)", d, cyc);
        end else begin
          mon_e = sb.pop_front();
          $display("rsp inst=%0d cyc=%0d rdata=%08h err=%0d", d, cyc, rsp_rdata_t[d], rsp_err_t[d]);
          chk("rsp_inst",  32'(d), 32'(mon_e.inst));
          chk("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
          chk("rsp_rdata", rsp_rdata_t[d], mon_e.rdata);
          chk("rsp_err",   32'(rsp_err_t[d]), 32'(mon_e.err));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic drive(input int d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] fn3);
    req_valid_t[d] = 1'b1;
    req_we_t[d]    = we;
    req_addr_t[d]  = addr;
    req_wdata_t[d] = wdata;
    req_fn3_t[d]   = fn3;
  endtask

  // Called on a negedge with the request driven; returns the accept edge index.
  task automatic wait_accept(input int d, output bit ok, output int unsigned t);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 30; i++) begin
      if (rdy_t[d] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) t = cyc + 1;
    else fail_now("accept_timeout");
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) return;
      @(negedge clk);
    end
    fail_now("rsp_timeout");
    sb.delete();
  endtask

  task automatic push_exp(input int d, input int unsigned t, input logic [31:0] rd, input logic er);
    exp_t e;
    e.inst  = d;
    e.cyc   = t + 2 + WAITS[d];
    e.rdata = rd;
    e.err   = er;
    sb.push_back(e);
  endtask

  // One complete transaction; use_exp selects a fixed expectation over the model's.
  task automatic send(input int d, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] fn3,
                      input bit use_exp, input logic [31:0] xr, input logic xe);
    logic [31:0] mr;
    logic        me;
    bit          ok;
    int unsigned t;
    model(d, we, addr, wdata, fn3, mr, me);
    @(negedge clk);
    drive(d, we, addr, wdata, fn3);
    wait_accept(d, ok, t);
    if (!ok) begin
      req_valid_t[d] = 1'b0;
      return;
    end
    $display("req inst=%0d we=%0d addr=%08h wdata=%08h fn3=%0d", d, we, addr, wdata, fn3);
    push_exp(d, t, use_exp ? xr : mr, use_exp ? xe : me);
    @(negedge clk);
    req_valid_t[d] = 1'b0;
    wait_rsp();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [2:0] legal_fn3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    bit          ok;
    int unsigned t;
    logic [31:0] mr;
    logic        me;

    rst_t       = '1;
    req_valid_t = '0;
    req_we_t    = '0;
    for (int d = 0; d < NDUT; d++) begin
      req_addr_t[d]  = '0;
      req_wdata_t[d] = '0;
      req_fn3_t[d]   = '0;
    end
    repeat (3) @(negedge clk);
    rst_t = '0;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk("reset_req_ready", 32'(rdy_t[d]), 32'd1);
      chk("reset_rsp_valid", 32'(rsp_valid_t[d]), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata_t[d], 32'd0);
      chk("reset_rsp_err",   32'(rsp_err_t[d]), 32'd0);
    end

    // Give every byte a known value so later loads are fully predictable.
    for (int d = 0; d < NDUT; d++)
      for (int a = 0; a < DEPTH; a += 4)
        send(d, 1'b1, 32'(a), $urandom, 3'd2, 1'b0, '0, 1'b0);

    // Basic store/load and byte merge (WAIT_CYCLES=0)
    send(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 1'b1, 32'h0, 1'b0);
    send(0, 1'b0, 32'h10, 32'h0,        3'd2, 1'b1, 32'hDEADBEEF, 1'b0);
    send(0, 1'b1, 32'h11, 32'h7F,       3'd0, 1'b1, 32'h0, 1'b0);
    send(0, 1'b0, 32'h10, 32'h0,        3'd2, 1'b1, 32'hDEAD7FEF, 1'b0);
    // Extension
    send(0, 1'b0, 32'h13, 32'h0, 3'd0, 1'b1, 32'hFFFFFFDE, 1'b0);
    send(0, 1'b0, 32'h13, 32'h0, 3'd4, 1'b1, 32'h000000DE, 1'b0);
    send(0, 1'b0, 32'h12, 32'h0, 3'd1, 1'b1, 32'hFFFFDEAD, 1'b0);
    send(0, 1'b0, 32'h12, 32'h0, 3'd5, 1'b1, 32'h0000DEAD, 1'b0);
    // Errors
    send(0, 1'b0, 32'h10, 32'h0, 3'd3, 1'b1, 32'h0, 1'b1);
    send(0, 1'b1, 32'(DEPTH-4), 32'hCAFEF00D, 3'd2, 1'b1, 32'h0, 1'b0);
    send(0, 1'b1, 32'(DEPTH-2), 32'h12345678, 3'd2, 1'b1, 32'h0, 1'b1);
    send(0, 1'b0, 32'(DEPTH-4), 32'h0, 3'd1, 1'b1, 32'hFFFFF00D, 1'b0);
    send(0, 1'b0, 32'(DEPTH-4), 32'h0, 3'd2, 1'b1, 32'hCAFEF00D, 1'b0);
    send(0, 1'b1, 32'h10, 32'h5555, 3'd5, 1'b1, 32'h0, 1'b1);
    send(0, 1'b0, 32'h10, 32'h0,    3'd2, 1'b1, 32'hDEAD7FEF, 1'b0);
    send(0, 1'b0, 32'hFFFFFFFC, 32'h0, 3'd2, 1'b1, 32'h0, 1'b1);
    // Misaligned word
    send(0, 1'b1, 32'h20, 32'h11223344, 3'd2, 1'b1, 32'h0, 1'b0);
    send(0, 1'b1, 32'h24, 32'h55,       3'd0, 1'b1, 32'h0, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
    send(0, 1'b0, 32'h21, 32'h0, 3'd2, 1'b1, 32'h0, 1'b1);
`else
    send(0, 1'b0, 32'h21, 32'h0, 3'd2, 1'b1, 32'h55112233, 1'b0);
`endif

    // WAIT_CYCLES=3: busy window and held req_valid
    send(1, 1'b1, 32'h40, 32'hA5A55A5A, 3'd2, 1'b1, 32'h0, 1'b0);
    model(1, 1'b0, 32'h40, 32'h0, 3'd2, mr, me);
    @(negedge clk);
    drive(1, 1'b0, 32'h40, 32'h0, 3'd2);
    wait_accept(1, ok, t);
    if (ok) begin
      $display("req inst=1 we=0 addr=00000040 held valid");
      push_exp(1, t, 32'hA5A55A5A, 1'b0);
      for (int k = 0; k < WAITS[1] + 2; k++) begin
        @(negedge clk);
        chk("ready_low_busy", 32'(rdy_t[1]), 32'd0);
      end
      @(negedge clk);
      chk("ready_after_rsp", 32'(rdy_t[1]), 32'd1);
      push_exp(1, cyc + 1, 32'hA5A55A5A, 1'b0);
      @(negedge clk);
    end
    req_valid_t[1] = 1'b0;
    wait_rsp();

    // WAIT_CYCLES=2: reset during WAIT discards the store
    send(2, 1'b1, 32'h30, 32'h0, 3'd2, 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    drive(2, 1'b1, 32'h30, 32'hAAAAAAAA, 3'd2);
    wait_accept(2, ok, t);
    @(negedge clk);
    req_valid_t[2] = 1'b0;
    rst_t[2]       = 1'b1;
    $display("req inst=2 we=1 addr=00000030 wdata=aaaaaaaa aborted by reset");
    @(negedge clk);
    rst_t[2] = 1'b0;
    chk("ready_after_rst", 32'(rdy_t[2]), 32'd1);
    chk("valid_after_rst", 32'(rsp_valid_t[2]), 32'd0);
    repeat (8) @(negedge clk);
    send(2, 1'b0, 32'h30, 32'h0, 3'd2, 1'b1, 32'h00000000, 1'b0);

    // Randomized traffic against the model
    for (int d = 0; d < NDUT; d++) begin
      for (int n = 0; n < 40; n++) begin
        bit          we;
        logic [2:0]  fn3;
        logic [31:0] addr;
        int          r;
        we  = 1'($urandom_range(0, 1));
        fn3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                          : legal_fn3[$urandom_range(0, 4)];
        r   = $urandom_range(0, 9);
        if (r == 0)      addr = $urandom;
        else if (r == 1) addr = 32'(DEPTH - $urandom_range(1, 4));
        else             addr = 32'($urandom_range(0, DEPTH - 1));
        send(d, we, addr, $urandom, fn3, 1'b0, '0, 1'b0);
      end
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
